// File: rtl/bist_pkg.sv
// Shared types and helpers for the parametrised BIST controller:
// FSM state encoding, default Galois feedback masks and the shift/feedback step.
package bist_pkg;

    // Controller states; also exported on the debug state port.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } bist_state_t;

    // Right-shifting Galois masks. Bit W-1 is the wrap-around term; the other
    // set bit is the inner tap (x^36 + x^11 + 1 and x^49 + x^9 + 1).
    localparam logic [35:0] TAPS_36 = 36'h8_0000_0800;
    localparam logic [48:0] TAPS_49 = 49'h1_0000_0000_0200;

    // One Galois step: shift right, and when a 1 falls out of bit 0 XOR the
    // mask back in. Works for any register width up to 64 bits; callers
    // zero-extend into the argument and truncate the result to their width.
    function automatic logic [63:0] galois_next(input logic [63:0] value,
                                                input logic [63:0] taps);
        return (value >> 1) ^ (value[0] ? taps : 64'd0);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois shift register used both as the pattern generator (data tied to 0)
// and as the MISR (data = CUT response). A load forces the INIT value,
// an enable advances one step and XORs the data word into the new state.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int           W     = 4,
    parameter int           OUT_W = W,
    parameter logic [W-1:0] TAPS  = '1,
    parameter logic [W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [W-1:0]     i_data,
    output logic [OUT_W-1:0] o_value
);

    logic [W-1:0] r_value;
    logic [W-1:0] w_step;

    assign w_step  = W'(galois_next(64'(r_value), 64'(TAPS))) ^ i_data;
    assign o_value = r_value[OUT_W-1:0];

    // State register: load has priority over stepping; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= INIT;
        end else if (i_load) begin
            r_value <= INIT;
        end else if (i_en) begin
            r_value <= w_step;
        end
    end

endmodule

// File: rtl/bist_ctrl_param.sv
// Parametrised BIST controller. Sits between the pins and a sequential CUT;
// in BIST mode it drives the CUT from an LFSR, compacts the responses into a
// MISR and compares the final signature with GOLDEN.
//
// bistmode is a level request: raising it starts a run, holding it keeps the
// run going and keeps the result visible in DONE; dropping it before COMPARE
// aborts, dropping it in DONE returns to IDLE. A new run needs a pass through
// IDLE. There is no valid/ready handshake on this block.
module bist_ctrl_param
    import bist_pkg::*;
#(
    parameter int                PI_W       = 35,
    parameter int                PO_W       = 49,
    parameter int                LFSR_W     = 36,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = TAPS_36,
    parameter logic [PO_W-1:0]   MISR_TAPS  = TAPS_49,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(1),
    parameter int                N_PATTERNS = 2000,
    parameter int                CUT_LAT    = 1,
    parameter logic [PO_W-1:0]   GOLDEN     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bistmode,
    input  logic [PI_W-1:0]   pi,
    output logic [PO_W-1:0]   po,
    output logic [PI_W-1:0]   cut_pi,
    input  logic [PO_W-1:0]   cut_po,
    output logic              bistdone,
    output logic              bistpass,
    output logic [PO_W-1:0]   sig,
    output bist_state_t       dbg_state
);

    localparam int CNT_W = $clog2(N_PATTERNS + 1);

    bist_state_t      r_state;
    bist_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_fcnt;
    logic             r_done;
    logic             r_pass;

    logic             w_init;
    logic             w_run;
    logic             w_valid;
    logic             w_last_pat;
    logic             w_last_flush;
    logic [PI_W-1:0]  w_pattern;
    logic [PO_W-1:0]  w_misr;

    assign w_init       = (r_state == S_INIT);
    assign w_run        = (r_state == S_RUN);
    assign w_last_pat   = (r_cnt == CNT_W'(N_PATTERNS - 1));
    assign w_last_flush = (r_fcnt == 3'(CUT_LAT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping bistmode before COMPARE aborts to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bistmode) w_next_state = S_INIT;
            end
            S_INIT: begin
                if (!bistmode) w_next_state = S_IDLE;
                else           w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!bistmode) begin
                    w_next_state = S_IDLE;
                end else if (w_last_pat) begin
                    if (CUT_LAT == 0) w_next_state = S_COMPARE;
                    else              w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!bistmode)         w_next_state = S_IDLE;
                else if (w_last_flush) w_next_state = S_COMPARE;
            end
            S_COMPARE: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (!bistmode) w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Pattern counter: cleared in INIT, counts RUN cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_init) begin
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Flush counter: counts FLUSH cycles so the last CUT_LAT responses drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fcnt <= '0;
        end else if (r_state == S_FLUSH) begin
            r_fcnt <= r_fcnt + 3'd1;
        end else begin
            r_fcnt <= '0;
        end
    end

    // Valid pipe: the RUN flag delayed by CUT_LAT cycles marks the edges on
    // which cut_po carries the response to an applied pattern.
    generate
        if (CUT_LAT == 0) begin : g_nopipe
            assign w_valid = w_run;
        end else if (CUT_LAT == 1) begin : g_pipe1
            logic r_vpipe;
            // Single-stage delay of the RUN flag, cleared on INIT.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vpipe <= 1'b0;
                end else if (w_init) begin
                    r_vpipe <= 1'b0;
                end else begin
                    r_vpipe <= w_run;
                end
            end
            assign w_valid = r_vpipe;
        end else begin : g_pipen
            logic [CUT_LAT-1:0] r_vpipe;
            // Multi-stage delay of the RUN flag, cleared on INIT.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vpipe <= '0;
                end else if (w_init) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[CUT_LAT-2:0], w_run};
                end
            end
            assign w_valid = r_vpipe[CUT_LAT-1];
        end
    endgenerate

    // Result flags: set on the edge leaving COMPARE, held through DONE,
    // cleared on any transition that does not land in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (r_state == S_COMPARE) begin
            r_done <= 1'b1;
            r_pass <= (w_misr == GOLDEN);
        end else if (w_next_state != S_DONE) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end
    end

    // Pattern generator: seeded in INIT, steps every RUN cycle, frozen otherwise.
    bist_lfsr #(
        .W     (LFSR_W),
        .OUT_W (PI_W),
        .TAPS  (LFSR_TAPS),
        .INIT  (SEED)
    ) u_gen (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_init),
        .i_en    (w_run),
        .i_data  ({LFSR_W{1'b0}}),
        .o_value (w_pattern)
    );

    // Response compactor: cleared in INIT, absorbs cut_po when the pipe says so.
    bist_lfsr #(
        .W     (PO_W),
        .OUT_W (PO_W),
        .TAPS  (MISR_TAPS),
        .INIT  ({PO_W{1'b0}})
    ) u_misr (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_init),
        .i_en    (w_valid),
        .i_data  (cut_po),
        .o_value (w_misr)
    );

    // Pins pass straight through in IDLE; any other state isolates the CUT
    // from the pins and feeds it the generator.
    assign cut_pi    = (r_state == S_IDLE) ? pi : w_pattern;
    assign po        = cut_po;
    assign sig       = w_misr;
    assign bistdone  = r_done;
    assign bistpass  = r_pass;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Bench for bist_ctrl_param in a 4-bit configuration with a one-register CUT
// stub. A reference model produces the applied patterns and final signatures.
module tb_bist_ctrl_param;
    import bist_pkg::*;

    localparam int         PI_W    = 4;
    localparam int         PO_W    = 4;
    localparam int         LFSR_W  = 4;
    localparam int         N_PAT   = 8;
    localparam int         CUT_LAT = 1;
    localparam logic [3:0] TAPS    = 4'b1001;
    localparam logic [3:0] SEED    = 4'd1;
    localparam logic [3:0] FAULT2  = 4'b0100;

    // Reference Galois step for the 4-bit registers.
    function automatic logic [3:0] gal4(input logic [3:0] v);
        logic [3:0] r;
        r = {1'b0, v[3:1]};
        if (v[0]) r = r ^ TAPS;
        return r;
    endfunction

    // Signature after nsteps compacted responses; fmask is ORed onto cut_po.
    function automatic logic [3:0] model_sig(input logic [3:0] fmask, input int nsteps);
        logic [3:0] l;
        logic [3:0] m;
        l = SEED;
        m = 4'd0;
        for (int i = 0; i < nsteps; i++) begin
            m = gal4(m) ^ (l | fmask);
            l = gal4(l);
        end
        return m;
    endfunction

    localparam logic [3:0] GOLDEN = model_sig(4'b0000, N_PAT);

    logic        clk;
    logic        rst;
    logic        bistmode;
    logic [3:0]  pi;
    logic [3:0]  po;
    logic [3:0]  cut_pi;
    logic [3:0]  cut_po;
    logic        bistdone;
    logic        bistpass;
    logic [3:0]  sig;
    bist_state_t dbg_state;

    logic [3:0]  r_cut;
    logic [3:0]  fault_mask;

    logic [3:0]  exp_q[$];
    logic [4:0]  res_q[$];

    int n_checks;
    int n_errors;

    bist_ctrl_param #(
        .PI_W       (PI_W),
        .PO_W       (PO_W),
        .LFSR_W     (LFSR_W),
        .LFSR_TAPS  (TAPS),
        .MISR_TAPS  (TAPS),
        .SEED       (SEED),
        .N_PATTERNS (N_PAT),
        .CUT_LAT    (CUT_LAT),
        .GOLDEN     (GOLDEN)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bistmode  (bistmode),
        .pi        (pi),
        .po        (po),
        .cut_pi    (cut_pi),
        .cut_po    (cut_po),
        .bistdone  (bistdone),
        .bistpass  (bistpass),
        .sig       (sig),
        .dbg_state (dbg_state)
    );

    // Clock and CUT stub (one register, optional stuck-at-1 overlay).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) r_cut <= cut_pi;
    assign cut_po = r_cut | fault_mask;

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Load the scoreboard for one run and raise bistmode; returns just after edge 0.
    task automatic start_run(input logic [3:0] fmask);
        logic [3:0] l;
        logic [3:0] s;
        fault_mask = fmask;
        exp_q.delete();
        res_q.delete();
        l = SEED;
        for (int i = 0; i < N_PAT; i++) begin
            exp_q.push_back(l);
            l = gal4(l);
        end
        s = model_sig(fmask, N_PAT);
        res_q.push_back({(s == GOLDEN), s});
        bistmode = 1'b1;
        @(posedge clk);
    endtask

    // Complete run: check each applied pattern, the done latency and the result.
    task automatic run_full(input logic [3:0] fmask);
        logic [3:0] e;
        logic [4:0] r;
        int         done_at;
        start_run(fmask);
        done_at = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            step();
            if (k <= N_PAT && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cut_pi_pattern", 32'(cut_pi), 32'(e));
            end
            if (bistdone) done_at = k;
        end
        if (done_at == 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", 32'(done_at), 32'(N_PAT + CUT_LAT + 2));
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                check("bistpass", 32'(bistpass), 32'(r[4]));
                check("sig", 32'(sig), 32'(r[3:0]));
            end else begin
                check("result_queue_empty", 32'd0, 32'd1);
            end
        end
    endtask

    initial begin
        logic [3:0] pi_v;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        bistmode   = 1'b0;
        pi         = 4'd0;
        fault_mask = 4'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bistdone), 32'd0);
        check("rst_pass", 32'(bistpass), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // Functional mode: pins pass through to the CUT and back.
        for (int i = 0; i < 3; i++) begin
            pi_v       = 4'($urandom_range(0, 15));
            pi         = pi_v;
            fault_mask = (i == 2) ? FAULT2 : 4'd0;
            #1;
            check("func_cut_pi", 32'(cut_pi), 32'(pi_v));
            @(negedge clk);
            check("func_po", 32'(po), 32'(pi_v | fault_mask));
        end
        fault_mask = 4'd0;
        pi = 4'hA;
        #1;
        check("func_cut_pi_A", 32'(cut_pi), 32'hA);
        @(negedge clk);
        check("func_po_A", 32'(po), 32'hA);

        // Fault-free run, then hold bistmode: must stay in DONE without re-running.
        run_full(4'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_done", 32'(bistdone), 32'd1);
            check("hold_state", 32'(dbg_state), 32'(S_DONE));
        end

        // Drop for one cycle, then run again.
        bistmode = 1'b0;
        step();
        check("gap_done", 32'(bistdone), 32'd0);
        check("gap_pass", 32'(bistpass), 32'd0);
        check("gap_state", 32'(dbg_state), 32'(S_IDLE));
        run_full(4'd0);
        bistmode = 1'b0;
        step();

        // Stuck-at-1 on cut_po[2].
        run_full(FAULT2);
        check("fault_sig_differs", 32'(sig != GOLDEN), 32'd1);
        bistmode = 1'b0;
        step();
        fault_mask = 4'd0;

        // Abort at RUN cnt = 4.
        pi_v = 4'($urandom_range(0, 15));
        pi   = pi_v;
        start_run(4'd0);
        repeat (5) step();
        check("abort_in_run", 32'(dbg_state), 32'(S_RUN));
        bistmode = 1'b0;
        step();
        check("abort_idle", 32'(dbg_state), 32'(S_IDLE));
        check("abort_cut_pi", 32'(cut_pi), 32'(pi_v));
        for (int i = 0; i < 12; i++) begin
            check("abort_no_done", 32'(bistdone), 32'd0);
            step();
        end

        // Reset asserted during FLUSH.
        start_run(FAULT2);
        repeat (N_PAT + 1) step();
        check("flush_state", 32'(dbg_state), 32'(S_FLUSH));
        check("flush_sig", 32'(sig), 32'(model_sig(FAULT2, N_PAT - 1)));
        #2;
        rst      = 1'b0;
        bistmode = 1'b0;
        #1;
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        check("arst_sig", 32'(sig), 32'd0);
        check("arst_done", 32'(bistdone), 32'd0);
        check("arst_pass", 32'(bistpass), 32'd0);
        check("arst_cut_pi", 32'(cut_pi), 32'(pi_v));
        @(negedge clk);
        rst = 1'b1;
        fault_mask = 4'd0;
        step();
        check("post_rst_done", 32'(bistdone), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_ctrl_param.md
# bist_ctrl_param

Parametrised BIST controller for sequential CUTs. It sits between the chip pins (`pi`/`po`) and the CUT. In BIST mode it drives the CUT inputs from an LFSR pattern generator and compacts the CUT outputs into a MISR. When the run finishes it compares the signature against a golden constant and reports through `bistdone`/`bistpass`. Compared with the fixed-width controller it generalises PI/PO width, pattern count and CUT pipeline latency, and adds clean abort and signature observation.

## Interface
- `PI_W`, 35, CUT primary-input width.
- `PO_W`, 49, CUT primary-output width; also the MISR width.
- `LFSR_W`, 36, generator width; must be ≥ `PI_W`.
- `LFSR_TAPS`, package default for 36, Galois feedback mask of the generator.
- `MISR_TAPS`, package default for 49, Galois feedback mask of the MISR.
- `SEED`, 1, generator reset/start value; must be non-zero.
- `N_PATTERNS`, 2000, number of patterns applied per run; must be ≥ 1.
- `CUT_LAT`, 1, cycles from `cut_pi` to the corresponding `cut_po`; range 0..7.
- `GOLDEN`, 0, expected final MISR value.
- `clk`, in, 1, sole clock, rising edge.
- `rst`, in, 1, asynchronous, active-low reset.
- `bistmode`, in, 1, requests and holds a BIST run.
- `pi`, in, `PI_W`, functional inputs from the pins.
- `po`, out, `PO_W`, pin outputs; equals `cut_po` at all times.
- `cut_pi`, out, `PI_W`, CUT inputs.
- `cut_po`, in, `PO_W`, CUT outputs.
- `bistdone`, out, 1, run complete.
- `bistpass`, out, 1, signature matched; valid only while `bistdone` = 1.
- `sig`, out, `PO_W`, current MISR contents.

## Operation
- States: IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- IDLE:
  - `cut_pi` = `pi`.
  - `bistmode` = 1 sampled → INIT.
- INIT, one cycle:
  - load lfsr = `SEED`, misr = 0, cnt = 0, clear the valid pipe.
  - next state → RUN.
- RUN:
  - `cut_pi` = lfsr[`PI_W`-1:0].
  - Each edge: lfsr advances and cnt increments.
  - After `N_PATTERNS` RUN cycles → FLUSH, or → COMPARE if `CUT_LAT` = 0.
- FLUSH, `CUT_LAT` cycles:
  - lfsr frozen; `cut_pi` keeps showing it.
  - next state → COMPARE.
- Valid pipe: a flag equal to (state == RUN), delayed `CUT_LAT` cycles. On each edge where the delayed flag is 1, the MISR absorbs: misr ← shift/feedback(misr) XOR `cut_po`. Exactly `N_PATTERNS` responses are compacted.
- COMPARE, one cycle: at its exit edge, `bistdone` ← 1 and `bistpass` ← (misr == `GOLDEN`); next state → DONE.
- DONE:
  - outputs held; MISR held.
  - `bistmode` = 0 → IDLE, clearing `bistdone` and `bistpass`.
- Abort: `bistmode` = 0 in INIT, RUN or FLUSH → IDLE next edge; `bistdone` stays 0 and `bistpass` stays 0.
- Restart: requires a return to IDLE. `bistmode` held high in DONE does not re-run.
- cnt width: $clog2(`N_PATTERNS`+1). Terminal compare is cnt == `N_PATTERNS`-1 in RUN.

## Timing
- Reset values: state IDLE, lfsr = `SEED`, misr = 0 (so `sig` = 0), cnt = 0, valid pipe = 0, `bistdone` = 0, `bistpass` = 0.
- `cut_pi` and `po` are combinational muxes with no register stage.
- Latency: the edge sampling `bistmode` = 1 is edge 0. `bistdone` rises at edge `N_PATTERNS` + `CUT_LAT` + 2.
- Reset asserted mid-run: immediate return to reset values; no partial `bistdone`.
- `bistmode` falling in the same cycle COMPARE completes: the edge still enters DONE, and the next edge returns to IDLE. `bistdone` is high for exactly one cycle.

## Structure
- Package `bist_pkg`:
  - state enum `bist_state_t`
  - default tap constants `TAPS_36`, `TAPS_49`
  - function `galois_next(value, taps)`
- One sub-module, `bist_lfsr` (params `W`, `TAPS`, `INIT`), instantiated twice:
  - generator: data input tied 0.
  - MISR: data input `cut_po`, enable driven by the valid pipe.
- The top level holds the FSM, the counter, the valid pipe and the muxes.

## Test plan
Bench configuration: `PI_W`=4, `PO_W`=4, `LFSR_W`=4, `LFSR_TAPS`=4'b1001, `MISR_TAPS`=4'b1001, `SEED`=1, `N_PATTERNS`=8, `CUT_LAT`=1. The CUT stub registers `cut_pi` onto `cut_po`. `GOLDEN` is computed by the bench model.

- Fault-free run: release reset, hold `bistmode` = 1. Required: `bistdone` rises exactly 11 edges after sampling, `bistpass` = 1, `sig` = `GOLDEN`.
- Back-to-back runs: drop `bistmode` for 1 cycle, then reassert. Required: identical `sig` and pass both times, and `bistdone` = 0 in between.
- Injected fault: force `cut_po`[2] = 1. Required: `bistdone` = 1, `bistpass` = 0, `sig` ≠ `GOLDEN`.
- Abort: drop `bistmode` at RUN cnt = 4. Required: IDLE next edge, `bistdone` never asserts, and `cut_pi` returns to `pi`.
- Reset mid-FLUSH: assert `rst` = 0 asynchronously. Required: all outputs return to reset values before the next edge.
- Functional mode: in IDLE drive `pi` = 4'hA. Required: `cut_pi` = 4'hA and `po` tracks `cut_po`.
